mem_master: RTL and testbench
=============================

Name: mem_master

Overview:
- Initiator for the processor's 18-bit data memory port. It drives re_en, wr_en, address and DataIn toward the memory and captures its registered DataOut.
- It accepts single read, burst read (1–8 beats) and single write requests from the core's fetch and load/store logic over a valid/ready handshake.
- It returns read data on a fixed-latency response stream.
- It guarantees the memory never sees re_en and wr_en high together and never sees an out-of-range address.

Parameters:
- DATA_W, 18, memory word width.
- ADDR_W, 13, memory address width.
- LEN_W, 3, burst length field width (beats minus 1).
- MEM_DEPTH, 128, number of implemented memory words; legal addresses are 0..MEM_DEPTH-1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset; shared with the memory.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  start address.
- req_len  in  LEN_W  read beats minus 1; ignored for writes.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response beat valid; no backpressure, consumer must sample.
- rsp_rdata  out  DATA_W  read data; 0 for write acks and errors.
- rsp_last  out  1  final beat of the request.
- rsp_err  out  1  request rejected as out of range.
- busy  out  1  inverse of req_ready.
- mem_re_en  out  1  memory read strobe.
- mem_wr_en  out  1  memory write strobe.
- mem_address  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  to memory DataIn.
- mem_rdata  in  DATA_W  from memory DataOut; registered in the memory, valid the cycle after re_en.

Behaviour:
- **Registered outputs.** Every output except busy is registered. busy = ~req_ready.
- **Reset.** State goes to IDLE. req_ready=1; all other outputs and counters are 0. Any in-flight burst is aborted, pending response beats are discarded, and no strobe is issued while rst=1.
- **Acceptance.** A request is accepted on the edge where req_valid && req_ready. Call that edge E0 and the cycle after it C1. req_ready drops in C1.
- **Range check at acceptance.** Compute end = req_addr + len in ADDR_W+1 bits; len=0 for writes. If end >= MEM_DEPTH, the request is rejected:
  - Go to ERR; no strobes at all.
  - In C1: rsp_valid=1, rsp_err=1, rsp_last=1, rsp_rdata=0.
  - IDLE in C2.
- **Write.** State WR.
  - C1: mem_wr_en=1, mem_address=A, mem_wdata=wdata.
  - C2: ack beat with rsp_valid=1, rsp_last=1, rsp_err=0, rdata=0.
  - IDLE in C3.
- **Read / burst read.** State RD_ISSUE.
  - Beat k (0..len) is issued in cycle C(1+k): mem_re_en=1, mem_address=A+k. One beat per cycle, no gaps.
  - The memory updates DataOut at the end of C(1+k). The block samples mem_rdata at the end of C(2+k).
  - rsp_valid for beat k is in C(3+k), so latency from E0 to the first beat is 3 cycles. Beats are contiguous.
  - rsp_last is set on beat len only.
  - After the final issue, go to RD_DRAIN until rsp_last is emitted; IDLE on the next cycle.
- **Tag pipeline.** A 2-stage valid/last tag pipeline tracks issued beats.
- **Strobe rules.**
  - mem_re_en and mem_wr_en are never both 1.
  - mem_address=0 and mem_wdata=0 whenever no strobe is asserted.
  - mem_rdata is ignored except in tagged sample cycles.
- **Requests while busy.** req_valid while req_ready=0 is not accepted; the request fields are not sampled.
- **Back-to-back requests.** The minimum accept-to-accept spacing is response end plus 1 cycle; there is no overlap of requests.

Decomposition:
- **Package mem_master_pkg:**
  - DATA_W, ADDR_W, LEN_W, MEM_DEPTH defaults.
  - State enum {IDLE, RD_ISSUE, RD_DRAIN, WR, ERR}.
  - Response tag struct {valid, last}.
- **Sub-module mem_rsp_pipe:** 2-stage tag shift register plus the data capture register producing rsp_valid, rsp_last and rsp_rdata. It has a flush on rst.

Test Plan:
- **Single read.** Reset (memory preloads Mem[21]=3), then read addr 21, len 0. Expect mem_re_en only in C1, then rsp_valid, rsp_rdata=18'd3 and rsp_last=1 in C3; req_ready=1 in C4.
- **Burst read.** Read addr 0, len 3. Expect mem_re_en C1–C4 with addresses 0,1,2,3, and 4 contiguous beats C3–C6 equal to the preloaded Mem[0..3]. rsp_last is set only in C6.
- **Write then read.** Write 18'h0002A to addr 30 and expect the ack in C2. Then read addr 30 and expect rsp_rdata=18'h0002A.
- **Out of range.** Read addr 126, len 3, then write addr 128. Each gives one beat with rsp_err=1 and rsp_rdata=0, and no mem strobes at all.
- **Busy hold.** Hold req_valid high with a second request throughout a len-7 burst. Expect it accepted exactly once, on the first edge after rsp_last.
- **Reset mid-burst.** Assert rst in C3 of a len-7 burst. Expect all strobes and rsp_valid 0 from the next cycle, and req_ready=1 after rst deasserts.

Source files
------------

// File: rtl/mem_master_pkg.sv
// Shared widths, FSM state encoding and response tag type for the data-memory initiator.
package mem_master_pkg;
    localparam int unsigned DATA_W    = 18;
    localparam int unsigned ADDR_W    = 13;
    localparam int unsigned LEN_W     = 3;
    localparam int unsigned MEM_DEPTH = 128;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DRAIN,
        WR,
        ERR
    } state_e;

    typedef struct packed {
        logic valid;
        logic last;
    } rsp_tag_t;
endpackage

// File: rtl/mem_master_if.sv
// Request, response and memory-port signals of mem_master; master = initiator side.
interface mem_master_if #(
    parameter int unsigned DATA_W = mem_master_pkg::DATA_W,
    parameter int unsigned ADDR_W = mem_master_pkg::ADDR_W,
    parameter int unsigned LEN_W  = mem_master_pkg::LEN_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_last;
    logic              rsp_err;
    logic              busy;
    logic              mem_re_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_len, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err, busy,
               mem_re_en, mem_wr_en, mem_address, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_err, busy,
               mem_re_en, mem_wr_en, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_rsp_pipe.sv
// Two-stage read tag pipeline plus registered response outputs; error/ack beats bypass the tags.
module mem_rsp_pipe
    import mem_master_pkg::*;
#(
    parameter int unsigned DATA_W = mem_master_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  rsp_tag_t          tag_i,
    input  logic              inj_valid_i,
    input  logic              inj_err_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              rsp_valid_o,
    output logic              rsp_last_o,
    output logic              rsp_err_o,
    output logic [DATA_W-1:0] rsp_rdata_o
);
    rsp_tag_t          stage0_q, stage1_q;
    logic              valid_d, last_d, err_d;
    logic              valid_q, last_q, err_q;
    logic [DATA_W-1:0] rdata_d, rdata_q;

    // stage1 lines up with the cycle the memory presents data for that beat
    always_comb begin
        valid_d = stage1_q.valid | inj_valid_i;
        last_d  = (stage1_q.valid & stage1_q.last) | inj_valid_i;
        err_d   = inj_valid_i & inj_err_i;
        rdata_d = stage1_q.valid ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage0_q <= '0;
            stage1_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            stage0_q <= tag_i;
            stage1_q <= stage0_q;
            valid_q  <= valid_d;
            last_q   <= last_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rsp_valid_o = valid_q;
    assign rsp_last_o  = last_q;
    assign rsp_err_o   = err_q;
    assign rsp_rdata_o = rdata_q;
endmodule

// File: rtl/mem_master.sv
// Data-memory initiator: single/burst reads and single writes with range check and fixed-latency responses.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int unsigned DATA_W    = mem_master_pkg::DATA_W,
    parameter int unsigned ADDR_W    = mem_master_pkg::ADDR_W,
    parameter int unsigned LEN_W     = mem_master_pkg::LEN_W,
    parameter int unsigned MEM_DEPTH = mem_master_pkg::MEM_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    mem_master_if.master bus
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              ready_q;
    logic              re_q, re_d, wr_q, wr_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    rsp_tag_t          tag_d;
    logic              inj_valid_d, inj_err_d;
    logic              accept, in_range;
    logic [ADDR_W:0]   end_addr;
    logic              rsp_valid_w, rsp_last_w, rsp_err_w;
    logic [DATA_W-1:0] rsp_rdata_w;

    assign accept   = bus.req_valid & ready_q;
    assign end_addr = {1'b0, bus.req_addr}
                    + (bus.req_write ? '0 : (ADDR_W+1)'(bus.req_len));
    assign in_range = end_addr < DEPTH_L;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            re_q     <= 1'b0;
            wr_q     <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            ready_q  <= (state_d == IDLE);
            re_q     <= re_d;
            wr_q     <= wr_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    // addr_q/cnt_q describe the next beat to issue; beat 0 is launched from IDLE
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_range)         state_d = ERR;
                    else if (bus.req_write) state_d = WR;
                    else begin
                        state_d = RD_ISSUE;
                        addr_d  = bus.req_addr + ADDR_W'(1);
                        cnt_d   = bus.req_len;
                    end
                end
            end
            RD_ISSUE: begin
                if (cnt_q == '0) state_d = RD_DRAIN;
                else begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q - LEN_W'(1);
                end
            end
            RD_DRAIN: if (rsp_valid_w && rsp_last_w) state_d = IDLE;
            WR:       if (!wr_q) state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        re_d        = 1'b0;
        wr_d        = 1'b0;
        maddr_d     = '0;
        mwdata_d    = '0;
        tag_d       = '0;
        inj_valid_d = 1'b0;
        inj_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_range) begin
                        inj_valid_d = 1'b1;
                        inj_err_d   = 1'b1;
                    end else if (bus.req_write) begin
                        wr_d     = 1'b1;
                        maddr_d  = bus.req_addr;
                        mwdata_d = bus.req_wdata;
                    end else begin
                        re_d    = 1'b1;
                        maddr_d = bus.req_addr;
                        tag_d   = '{valid: 1'b1, last: (bus.req_len == '0)};
                    end
                end
            end
            RD_ISSUE: begin
                if (cnt_q != '0) begin
                    re_d    = 1'b1;
                    maddr_d = addr_q;
                    tag_d   = '{valid: 1'b1, last: (cnt_q == LEN_W'(1))};
                end
            end
            WR:      inj_valid_d = wr_q;
            default: ;
        endcase
    end

    mem_rsp_pipe #(.DATA_W(DATA_W)) u_rsp_pipe (
        .clk         (clk),
        .rst         (rst),
        .tag_i       (tag_d),
        .inj_valid_i (inj_valid_d),
        .inj_err_i   (inj_err_d),
        .mem_rdata_i (bus.mem_rdata),
        .rsp_valid_o (rsp_valid_w),
        .rsp_last_o  (rsp_last_w),
        .rsp_err_o   (rsp_err_w),
        .rsp_rdata_o (rsp_rdata_w)
    );

    assign bus.req_ready   = ready_q;
    assign bus.busy        = ~ready_q;
    assign bus.mem_re_en   = re_q;
    assign bus.mem_wr_en   = wr_q;
    assign bus.mem_address = maddr_q;
    assign bus.mem_wdata   = mwdata_q;
    assign bus.rsp_valid   = rsp_valid_w;
    assign bus.rsp_last    = rsp_last_w;
    assign bus.rsp_err     = rsp_err_w;
    assign bus.rsp_rdata   = rsp_rdata_w;
endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: memory model, per-cycle expectation table built from request timing rules.
module tb_mem_master;
    import mem_master_pkg::*;

    localparam int NCYC = 4096;

    typedef struct packed {
        logic              re;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              rv;
        logic              last;
        logic              err;
        logic [DATA_W-1:0] rdata;
        logic              ready;
    } exp_t;

    typedef struct {
        int                c;
        logic [DATA_W-1:0] d;
        logic              last;
        logic              err;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_master_if bus ();

    mem_master #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // memory with registered DataOut
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] dout;
    assign bus.mem_rdata = dout;

    initial begin
        for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] <= DATA_W'(i * 37 + 5);
        mem[21] <= DATA_W'(3);
    end

    always @(posedge clk) begin
        if (rst) dout <= '0;
        else begin
            if (bus.mem_re_en && bus.mem_address < ADDR_W'(MEM_DEPTH))
                dout <= mem[int'(bus.mem_address)];
            if (bus.mem_wr_en && bus.mem_address < ADDR_W'(MEM_DEPTH))
                mem[int'(bus.mem_address)] <= bus.mem_wdata;
        end
    end

    int    cyc = 0, checks = 0, fails = 0;
    int    acc_cnt = 0, acc_cyc = 0, strobes = 0;
    bit    seen_rst = 1'b0;
    exp_t  ex [NCYC];
    exp_t  ce;
    logic [DATA_W-1:0] shadow [MEM_DEPTH];
    beat_t rq [$];

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Request timeline from acceptance cycle c1 (= C1)
    task automatic model_accept(input int c1);
        int a, l, e;
        a = int'(bus.req_addr);
        l = bus.req_write ? 0 : int'(bus.req_len);
        e = a + l;
        acc_cnt++;
        acc_cyc = c1;
        if (e >= int'(MEM_DEPTH)) begin
            ex[c1].ready = 1'b0;
            ex[c1].rv    = 1'b1;
            ex[c1].err   = 1'b1;
            ex[c1].last  = 1'b1;
        end else if (bus.req_write) begin
            ex[c1].wr      = 1'b1;
            ex[c1].addr    = bus.req_addr;
            ex[c1].wdata   = bus.req_wdata;
            ex[c1].ready   = 1'b0;
            ex[c1+1].ready = 1'b0;
            ex[c1+1].rv    = 1'b1;
            ex[c1+1].last  = 1'b1;
            shadow[a] = bus.req_wdata;
        end else begin
            for (int k = 0; k <= l; k++) begin
                ex[c1+k].re      = 1'b1;
                ex[c1+k].addr    = ADDR_W'(a + k);
                ex[c1+2+k].rv    = 1'b1;
                ex[c1+2+k].rdata = shadow[a+k];
                ex[c1+2+k].last  = (k == l);
            end
            for (int j = 0; j <= 2 + l; j++) ex[c1+j].ready = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < NCYC; i++) ex[i] = idle_e();
        for (int i = 0; i < int'(MEM_DEPTH); i++) shadow[i] = DATA_W'(i * 37 + 5);
        shadow[21] = DATA_W'(3);
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc < NCYC - 32) begin
                if (rst) begin
                    seen_rst = 1'b1;
                    for (int i = 0; i < 24; i++) ex[cyc+i] = idle_e();
                end else if (seen_rst && bus.req_valid && ex[cyc-1].ready) begin
                    model_accept(cyc);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (seen_rst && cyc < NCYC) begin
                ce = ex[cyc];
                chk("mem_re_en",   32'(bus.mem_re_en),   32'(ce.re));
                chk("mem_wr_en",   32'(bus.mem_wr_en),   32'(ce.wr));
                chk("mem_address", 32'(bus.mem_address), 32'(ce.addr));
                chk("mem_wdata",   32'(bus.mem_wdata),   32'(ce.wdata));
                chk("rsp_valid",   32'(bus.rsp_valid),   32'(ce.rv));
                chk("rsp_last",    32'(bus.rsp_last),    32'(ce.last));
                chk("rsp_err",     32'(bus.rsp_err),     32'(ce.err));
                chk("rsp_rdata",   32'(bus.rsp_rdata),   32'(ce.rdata));
                chk("req_ready",   32'(bus.req_ready),   32'(ce.ready));
                chk("busy",        32'(bus.busy),        32'(!ce.ready));
                if (bus.mem_re_en === 1'b1 || bus.mem_wr_en === 1'b1) strobes++;
                if (bus.rsp_valid === 1'b1)
                    rq.push_back('{cyc, bus.rsp_rdata, bus.rsp_last, bus.rsp_err});
            end
        end
    end

    task automatic send(input logic w, input int a, input int l, input logic [DATA_W-1:0] d);
        int n0, t;
        n0 = acc_cnt;
        t  = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = ADDR_W'(a);
        bus.req_len   = LEN_W'(l);
        bus.req_wdata = d;
        while (acc_cnt == n0 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (acc_cnt == n0) chk("accept_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b0;
        bus.req_addr  = ADDR_W'($urandom);
        bus.req_len   = LEN_W'($urandom);
        bus.req_wdata = DATA_W'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.req_ready !== 1'b1 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (bus.req_ready !== 1'b1) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int a, a1, a2, n0, t, s0;
        logic [DATA_W-1:0] lit [4];
        lit[0] = 18'd5; lit[1] = 18'd42; lit[2] = 18'd79; lit[3] = 18'd116;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single read of preloaded word
        rq.delete();
        send(1'b0, 21, 0, '0);
        a = acc_cyc;
        wait_idle();
        chk("rd1_ready_cycle", 32'(cyc - a), 32'd3);
        chk("rd1_beats", 32'(rq.size()), 32'd1);
        if (rq.size() == 1) begin
            chk("rd1_cycle", 32'(rq[0].c - a), 32'd2);
            chk("rd1_data",  32'(rq[0].d), 32'd3);
            chk("rd1_last",  32'(rq[0].last), 32'd1);
        end

        // burst of four
        rq.delete();
        send(1'b0, 0, 3, '0);
        a = acc_cyc;
        wait_idle();
        chk("burst_beats", 32'(rq.size()), 32'd4);
        if (rq.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("burst_cycle", 32'(rq[k].c - a), 32'(2 + k));
                chk("burst_data",  32'(rq[k].d), 32'(lit[k]));
                chk("burst_last",  32'(rq[k].last), 32'(k == 3));
            end
        end

        // write then read back
        rq.delete();
        send(1'b1, 30, 0, 18'h0002A);
        a = acc_cyc;
        wait_idle();
        chk("wr_beats", 32'(rq.size()), 32'd1);
        if (rq.size() == 1) begin
            chk("wr_ack_cycle", 32'(rq[0].c - a), 32'd1);
            chk("wr_ack_data",  32'(rq[0].d), 32'd0);
        end
        rq.delete();
        send(1'b0, 30, 0, '0);
        wait_idle();
        if (rq.size() == 1) chk("wr_readback", 32'(rq[0].d), 32'h2A);
        else chk("wr_readback_beats", 32'(rq.size()), 32'd1);

        // out of range read and write
        rq.delete();
        s0 = strobes;
        send(1'b0, 126, 3, '0);
        wait_idle();
        send(1'b1, 128, 0, 18'h3FFFF);
        wait_idle();
        chk("oor_strobes", 32'(strobes - s0), 32'd0);
        chk("oor_beats", 32'(rq.size()), 32'd2);
        if (rq.size() == 2) begin
            chk("oor_err0",  32'(rq[0].err), 32'd1);
            chk("oor_err1",  32'(rq[1].err), 32'd1);
            chk("oor_data1", 32'(rq[1].d), 32'd0);
        end

        // second request held through a len-7 burst
        n0 = acc_cnt;
        t  = 0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = ADDR_W'(8);
        bus.req_len   = LEN_W'(7);
        while (acc_cnt == n0 && t < 64) begin @(negedge clk); t++; end
        a1 = acc_cyc;
        bus.req_write = 1'b1;
        bus.req_addr  = ADDR_W'(50);
        bus.req_wdata = 18'h00155;
        t = 0;
        while (acc_cnt < n0 + 2 && t < 64) begin @(negedge clk); t++; end
        a2 = acc_cyc;
        bus.req_valid = 1'b0;
        if (acc_cnt < n0 + 2) chk("hold_timeout", 32'd0, 32'd1);
        chk("hold_spacing", 32'(a2 - a1), 32'd11);
        wait_idle();
        rq.delete();
        send(1'b0, 50, 0, '0);
        wait_idle();
        if (rq.size() == 1) chk("hold_readback", 32'(rq[0].d), 32'h155);
        else chk("hold_readback_beats", 32'(rq.size()), 32'd1);

        // reset in C3 of a len-7 burst
        send(1'b0, 10, 7, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_re_en", 32'(bus.mem_re_en), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_re_after", 32'(bus.mem_re_en), 32'd0);

        // random traffic, sometimes back-to-back while busy
        for (int i = 0; i < 80; i++) begin
            send(($urandom_range(0, 3) == 0), int'($urandom_range(0, 140)),
                 int'($urandom_range(0, 7)), DATA_W'($urandom));
            if ($urandom_range(0, 1) == 1) wait_idle();
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        wait_idle();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
